// File: rtl/ysyx_23060203_pkg.sv
// ysyx_23060203_pkg -- shared constants and types for the write-back unit.
//   NR_REG_DEFAULT : number of architectural GPRs (RV32E, x0 hardwired to zero)
//   REG_W          : register-index width
//   XLEN           : datapath width
//   CNT_W          : width of the per-register pending-write counter
package ysyx_23060203_pkg;

  localparam int NR_REG_DEFAULT = 16;
  localparam int REG_W          = 4;
  localparam int XLEN           = 32;
  localparam int CNT_W          = 2;

  // Saturation value of a pending counter; issue stalls here.
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // The single write-back slot that drives the GPR write master.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] addr;
    logic [XLEN-1:0]  data;
  } wb_req_t;

endpackage

// File: rtl/ysyx_23060203_wbu_arb.sv
// ysyx_23060203_wbu_arb -- 2-way round-robin arbiter between the EXU and LSU
// result channels.
//   clock, reset         : clock, asynchronous active-high reset
//   exu_valid, lsu_valid : requests from the two result channels
//   exu_grant, lsu_grant : one-hot (or zero) grant, only to a requesting channel
// The write-back slot retires every cycle, so a grant is always an acceptance
// and the last-grant pointer advances on every grant.
module ysyx_23060203_wbu_arb (
  input  logic clock,
  input  logic reset,
  input  logic exu_valid,
  input  logic lsu_valid,
  output logic exu_grant,
  output logic lsu_grant
);

  localparam logic [0:0] LAST_EXU = 1'b0;
  localparam logic [0:0] LAST_LSU = 1'b1;

  logic [0:0] last_q;

  // NOTE: every output of a combinational block is assigned on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    // With both requesting, the channel that did not win last time wins.
    exu_grant = exu_valid && (!lsu_valid || (last_q == LAST_LSU));
    lsu_grant = lsu_valid && !exu_grant;
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_q <= LAST_EXU;  // makes LSU the first winner of a tie
    end else if (exu_grant) begin
      last_q <= LAST_EXU;
    end else if (lsu_grant) begin
      last_q <= LAST_LSU;
    end
  end

endmodule

// File: rtl/ysyx_23060203_wbu.sv
// ysyx_23060203_wbu -- write-back unit.
// Arbitrates the EXU and LSU result channels into a single registered GPR
// write port and keeps a per-register pending-write scoreboard used by issue
// to stall on WAW overflow and by decode for RAW hazard queries.
//   clock, reset                  : clock, asynchronous active-high reset
//   exu_valid/ready/rd/data       : EXU result channel
//   lsu_valid/ready/rd/data       : LSU load-result channel
//   iss_valid/ready/rd            : issue reserves a destination register
//   qry_rs1/2 -> qry_busy1/2      : combinational hazard query
//   gpr_wen/waddr/wdata           : GPR file write master (registered)
// Optional feature, macro YSYX_23060203_WBU_BYPASS_EN: a query hitting the
// last outstanding write that retires this cycle reports not-busy and the
// value is provided on qry_fwd_data1/2.
module ysyx_23060203_wbu
  import ysyx_23060203_pkg::*;
#(
  parameter int NR_REG = NR_REG_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             exu_valid,
  output logic             exu_ready,
  input  logic [REG_W-1:0] exu_rd,
  input  logic [XLEN-1:0]  exu_data,
  input  logic             lsu_valid,
  output logic             lsu_ready,
  input  logic [REG_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]  lsu_data,
  input  logic             iss_valid,
  output logic             iss_ready,
  input  logic [REG_W-1:0] iss_rd,
  input  logic [REG_W-1:0] qry_rs1,
  input  logic [REG_W-1:0] qry_rs2,
  output logic             qry_busy1,
  output logic             qry_busy2,
  output logic             gpr_wen,
  output logic [REG_W-1:0] gpr_waddr,
  output logic [XLEN-1:0]  gpr_wdata
`ifdef YSYX_23060203_WBU_BYPASS_EN
  ,
  output logic [XLEN-1:0]  qry_fwd_data1,
  output logic [XLEN-1:0]  qry_fwd_data2
`endif
);

  wb_req_t                       wb_q;
  logic [NR_REG-1:0][CNT_W-1:0]  cnt_q;    // entry 0 never increments
  logic [NR_REG-1:0]             inc_vec;
  logic [NR_REG-1:0]             dec_vec;
  logic                          exu_fire;
  logic                          lsu_fire;
  logic                          iss_fire;
  logic                          retire_at_zero;

  // Pending count of a register; x0 and indices beyond NR_REG read as zero.
  function automatic logic [CNT_W-1:0] cnt_of(input logic [REG_W-1:0] idx);
    if (idx == '0 || 32'(idx) >= NR_REG) return '0;
    return cnt_q[idx];
  endfunction

  // ---------------------------------------------------------------------------
  // Result arbitration. The slot retires unconditionally each cycle, so the
  // ready of a channel is exactly its grant.
  // ---------------------------------------------------------------------------
  ysyx_23060203_wbu_arb u_arb (
    .clock     (clock),
    .reset     (reset),
    .exu_valid (exu_valid),
    .lsu_valid (lsu_valid),
    .exu_grant (exu_ready),
    .lsu_grant (lsu_ready)
  );

  assign exu_fire = exu_valid && exu_ready;
  assign lsu_fire = lsu_valid && lsu_ready;

  // ---------------------------------------------------------------------------
  // Write-back slot: loaded on acceptance, otherwise emptied after one cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_q <= '0;
    end else if (exu_fire) begin
      wb_q <= '{valid: 1'b1, addr: exu_rd, data: exu_data};
    end else if (lsu_fire) begin
      wb_q <= '{valid: 1'b1, addr: lsu_rd, data: lsu_data};
    end else begin
      wb_q.valid <= 1'b0;
    end
  end

  assign gpr_wen   = wb_q.valid;
  assign gpr_waddr = wb_q.addr;
  assign gpr_wdata = wb_q.data;

  // ---------------------------------------------------------------------------
  // Pending-write scoreboard.
  // A retire in the same cycle does not lift the stall: the count is still 3
  // when issue is evaluated, which keeps the ready path off the retire logic.
  // ---------------------------------------------------------------------------
  assign iss_ready = !((iss_rd != '0) && (cnt_of(iss_rd) == CNT_MAX));
  assign iss_fire  = iss_valid && iss_ready;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int i = 1; i < NR_REG; i++) begin
      inc_vec[i] = iss_fire && (32'(iss_rd) == i);
      // A retire against an empty counter is dropped rather than wrapping.
      dec_vec[i] = wb_q.valid && (32'(wb_q.addr) == i) && (cnt_q[i] != '0);
    end
  end

  // NOTE: the counter array is architectural state that hazard checks read
  // straight after reset, so unlike a data RAM it must be reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      for (int i = 1; i < NR_REG; i++) begin
        if (inc_vec[i] && !dec_vec[i]) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end else if (dec_vec[i] && !inc_vec[i]) begin
          cnt_q[i] <= cnt_q[i] - 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard query.
  // ---------------------------------------------------------------------------
  always_comb begin
    qry_busy1 = (qry_rs1 != '0) && (cnt_of(qry_rs1) != '0);
    qry_busy2 = (qry_rs2 != '0) && (cnt_of(qry_rs2) != '0);
`ifdef YSYX_23060203_WBU_BYPASS_EN
    // The only outstanding write is the one on the GPR port right now.
    if (wb_q.valid && (wb_q.addr == qry_rs1) && (cnt_of(qry_rs1) == CNT_W'(1)))
      qry_busy1 = 1'b0;
    if (wb_q.valid && (wb_q.addr == qry_rs2) && (cnt_of(qry_rs2) == CNT_W'(1)))
      qry_busy2 = 1'b0;
`endif
  end

`ifdef YSYX_23060203_WBU_BYPASS_EN
  assign qry_fwd_data1 = wb_q.data;
  assign qry_fwd_data2 = wb_q.data;
`endif

  // A retire to a register with nothing pending is a producer protocol error.
  assign retire_at_zero = wb_q.valid && (wb_q.addr != '0) && (cnt_of(wb_q.addr) == '0);

  a_retire_pending : assert property (@(posedge clock) disable iff (reset) !retire_at_zero);

endmodule

// File: tb/tb_ysyx_23060203_wbu.sv
// tb_ysyx_23060203_wbu -- scoreboard bench for the write-back unit.
// A stimulus process drives one cycle at a time, checks the handshake and
// hazard outputs against a reference model and pushes every accepted result
// into an expected-write queue; a monitor process pops that queue whenever
// the GPR write port is active.
module tb_ysyx_23060203_wbu;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        exu_valid, exu_ready, lsu_valid, lsu_ready, iss_valid, iss_ready;
  logic [3:0]  exu_rd, lsu_rd, iss_rd, qry_rs1, qry_rs2, gpr_waddr;
  logic [31:0] exu_data, lsu_data, gpr_wdata;
  logic        qry_busy1, qry_busy2, gpr_wen;
`ifdef YSYX_23060203_WBU_BYPASS_EN
  logic [31:0] qry_fwd_data1, qry_fwd_data2;
`endif

  ysyx_23060203_wbu #(.NR_REG(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .exu_valid (exu_valid),
    .exu_ready (exu_ready),
    .exu_rd    (exu_rd),
    .exu_data  (exu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .iss_valid (iss_valid),
    .iss_ready (iss_ready),
    .iss_rd    (iss_rd),
    .qry_rs1   (qry_rs1),
    .qry_rs2   (qry_rs2),
    .qry_busy1 (qry_busy1),
    .qry_busy2 (qry_busy2),
    .gpr_wen   (gpr_wen),
    .gpr_waddr (gpr_waddr),
    .gpr_wdata (gpr_wdata)
`ifdef YSYX_23060203_WBU_BYPASS_EN
    ,
    .qry_fwd_data1 (qry_fwd_data1),
    .qry_fwd_data2 (qry_fwd_data2)
`endif
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] data;
    int          due;
  } wr_t;

  typedef struct {
    bit          ev;
    logic [3:0]  erd;
    logic [31:0] ed;
    bit          lv;
    logic [3:0]  lrd;
    logic [31:0] ld;
    bit          iv;
    logic [3:0]  ird;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
  } stim_t;

  wr_t exp_q[$];

  // Reference model state.
  int          cnt_m[16];    // outstanding writes per register
  int          avail[16];    // issued but not yet answered by a result
  bit          last_lsu_m;   // the previous grant went to LSU
  bit          ret_v;        // a write is on the GPR port this cycle
  logic [3:0]  ret_rd;
  logic [31:0] ret_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit exp_busy(input logic [3:0] rs);
    if (rs == 4'd0) return 1'b0;
`ifdef YSYX_23060203_WBU_BYPASS_EN
    if (ret_v && ret_rd == rs && cnt_m[rs] == 1) return 1'b0;
`endif
    return cnt_m[rs] != 0;
  endfunction

  function automatic stim_t idle(input logic [3:0] rs1, input logic [3:0] rs2);
    stim_t s;
    s = '{ev: 1'b0, erd: 4'd0, ed: 32'd0, lv: 1'b0, lrd: 4'd0, ld: 32'd0,
          iv: 1'b0, ird: 4'd0, rs1: rs1, rs2: rs2};
    return s;
  endfunction

  // A destination that is legal for a result: x0 or one with an open issue.
  function automatic logic [3:0] pick_rd();
    int cands[$];
    cands.push_back(0);
    for (int i = 1; i < 16; i++) if (avail[i] > 0) cands.push_back(i);
    return 4'(cands[$urandom % cands.size()]);
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < 16; i++) begin
      cnt_m[i] = 0;
      avail[i] = 0;
    end
    last_lsu_m = 1'b0;
    ret_v      = 1'b0;
    ret_rd     = 4'd0;
    ret_data   = 32'd0;
  endfunction

  task automatic apply(input stim_t s);
    exu_valid = s.ev;  exu_rd = s.erd;  exu_data = s.ed;
    lsu_valid = s.lv;  lsu_rd = s.lrd;  lsu_data = s.ld;
    iss_valid = s.iv;  iss_rd = s.ird;
    qry_rs1   = s.rs1; qry_rs2 = s.rs2;
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic step(input stim_t s);
    bit ge, gl, ir, inc, dec;
    apply(s);
    @(negedge clock);
    ge = s.ev && (!s.lv || last_lsu_m);
    gl = s.lv && !ge;
    ir = !(s.ird != 4'd0 && cnt_m[s.ird] == 3);
    check("exu_ready", exu_ready, ge);
    check("lsu_ready", lsu_ready, gl);
    check("iss_ready", iss_ready, ir);
    check("qry_busy1", qry_busy1, exp_busy(s.rs1));
    check("qry_busy2", qry_busy2, exp_busy(s.rs2));
`ifdef YSYX_23060203_WBU_BYPASS_EN
    if (ret_v) begin
      check("qry_fwd_data1", qry_fwd_data1, ret_data);
      check("qry_fwd_data2", qry_fwd_data2, ret_data);
    end
`endif
    inc = s.iv && ir && s.ird != 4'd0;
    dec = ret_v && ret_rd != 4'd0;
    if (!(inc && dec && s.ird == ret_rd)) begin
      if (inc) cnt_m[s.ird]++;
      if (dec && cnt_m[ret_rd] > 0) cnt_m[ret_rd]--;
    end
    if (inc) avail[s.ird]++;
    ret_v = 1'b0;
    if (ge) begin
      exp_q.push_back('{rd: s.erd, data: s.ed, due: cyc + 1});
      last_lsu_m = 1'b0;
      ret_v = 1'b1; ret_rd = s.erd; ret_data = s.ed;
      if (s.erd != 4'd0) avail[s.erd]--;
    end else if (gl) begin
      exp_q.push_back('{rd: s.lrd, data: s.ld, due: cyc + 1});
      last_lsu_m = 1'b1;
      ret_v = 1'b1; ret_rd = s.lrd; ret_data = s.ld;
      if (s.lrd != 4'd0) avail[s.lrd]--;
    end
    @(posedge clock);
    #1;
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic do_reset(input logic [3:0] rs);
    apply(idle(rs, rs));
    reset = 1'b1;
    #1;
    check("rst_gpr_wen", gpr_wen, 1'b0);
    check("rst_gpr_waddr", gpr_waddr, 4'd0);
    check("rst_gpr_wdata", gpr_wdata, 32'd0);
    check("rst_qry_busy1", qry_busy1, 1'b0);
    check("rst_qry_busy2", qry_busy2, 1'b0);
    check("rst_iss_ready", iss_ready, 1'b1);
    exp_q.delete();
    clear_model();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  // Monitor: every active GPR write must match the oldest expected write.
  initial begin : monitor
    wr_t w;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (gpr_wen) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write: got gpr_wen=1 waddr=%0d wdata=0x%08h expected no write (cycle %0d)",
                     gpr_waddr, gpr_wdata, cyc);
          end else begin
            w = exp_q.pop_front();
            check("gpr_waddr", gpr_waddr, w.rd);
            check("gpr_wdata", gpr_wdata, w.data);
            check("write_cycle", cyc, w.due);
          end
        end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          w = exp_q.pop_front();
          checks++;
          failures++;
          $display("FAIL missing_write: got gpr_wen=0 expected write rd=%0d data=0x%08h (cycle %0d)",
                   w.rd, w.data, cyc);
        end
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    clear_model();
    apply(idle(4'd0, 4'd0));
    @(posedge clock);
    #1;
    do_reset(4'd5);

    // Single EXU result: write appears one cycle after acceptance, then clears.
    s = idle(4'd5, 4'd0); s.iv = 1'b1; s.ird = 4'd5; step(s);
    s = idle(4'd5, 4'd0); s.ev = 1'b1; s.erd = 4'd5; s.ed = 32'hDEADBEEF; step(s);
    check("single_wen_set", gpr_wen, 1'b1);
    step(idle(4'd5, 4'd0));
    check("single_wen_clear", gpr_wen, 1'b0);

    // Both channels valid for four cycles: LSU, EXU, LSU, EXU.
    for (int i = 0; i < 4; i++) begin
      s = idle(4'd0, 4'd0); s.iv = 1'b1; s.ird = (i % 2 == 0) ? 4'd1 : 4'd2; step(s);
    end
    for (int i = 0; i < 4; i++) begin
      s = idle(4'd1, 4'd2);
      s.ev = 1'b1; s.erd = 4'd1; s.ed = 32'h1000_0000 + 32'(i);
      s.lv = 1'b1; s.lrd = 4'd2; s.ld = 32'h2000_0000 + 32'(i);
      step(s);
    end

    // Saturate x7, stall the fourth issue, release after a retire.
    for (int i = 0; i < 3; i++) begin
      s = idle(4'd7, 4'd0); s.iv = 1'b1; s.ird = 4'd7; step(s);
    end
    s = idle(4'd7, 4'd0); s.iv = 1'b1; s.ird = 4'd7; step(s);
    s = idle(4'd7, 4'd0); s.iv = 1'b1; s.ird = 4'd7;
    s.ev = 1'b1; s.erd = 4'd7; s.ed = 32'h0000_7777; step(s);
    s = idle(4'd7, 4'd0); s.iv = 1'b1; s.ird = 4'd7; step(s);
    s = idle(4'd7, 4'd0); s.iv = 1'b1; s.ird = 4'd7; step(s);

    // Issue and retire of x3 in the same cycle with one write outstanding.
    s = idle(4'd3, 4'd0); s.iv = 1'b1; s.ird = 4'd3; step(s);
    s = idle(4'd3, 4'd0); s.ev = 1'b1; s.erd = 4'd3; s.ed = 32'hCAFE_0003; step(s);
    s = idle(4'd3, 4'd3); s.iv = 1'b1; s.ird = 4'd3; step(s);
    step(idle(4'd3, 4'd0));

    // x0 result and x0 issue leave the scoreboard untouched.
    s = idle(4'd0, 4'd0); s.ev = 1'b1; s.erd = 4'd0; s.ed = 32'h0BAD_F00D;
    s.iv = 1'b1; s.ird = 4'd0; step(s);
    check("x0_write_wen", gpr_wen, 1'b1);
    check("x0_write_addr", gpr_waddr, 4'd0);
    step(idle(4'd0, 4'd0));

    // Reset while a write is on the port and counters are non-zero.
    s = idle(4'd9, 4'd0); s.iv = 1'b1; s.ird = 4'd9; step(s);
    step(s);
    s = idle(4'd9, 4'd0); s.ev = 1'b1; s.erd = 4'd9; s.ed = 32'h9999_0009; step(s);
    check("pre_reset_wen", gpr_wen, 1'b1);
    do_reset(4'd9);
    s = idle(4'd9, 4'd0);
    s.ev = 1'b1; s.erd = 4'd0; s.ed = 32'hE0E0_E0E0;
    s.lv = 1'b1; s.lrd = 4'd0; s.ld = 32'h1515_1515;
    step(s);

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      s.ev  = 1'($urandom % 2);
      s.erd = pick_rd();
      s.ed  = $urandom;
      s.lv  = 1'($urandom % 2);
      s.lrd = pick_rd();
      s.ld  = $urandom;
      s.iv  = ($urandom % 3) != 0;
      s.ird = 4'($urandom % 16);
      s.rs1 = 4'($urandom % 16);
      s.rs2 = 4'($urandom % 16);
      step(s);
    end

    // Drain and sweep every register through the query ports.
    for (int i = 0; i < 3; i++) step(idle(4'd0, 4'd0));
    for (int i = 0; i < 16; i++) step(idle(4'(i), 4'(15 - i)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
